// File: rtl/lvds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_pkg
//  Brief    : Shared types and helpers for the LVDS frame writer: FSM state
//             encoding, channel-select width helper and header field layout.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package lvds_pkg;

  // Frame writer FSM states. HDR is only reachable when the header build
  // option is enabled.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_SKIP = 3'd3,
    ST_GAP  = 3'd4
  } lvds_state_t;

  // Channel-select width; a single-channel build still carries one select bit.
  function automatic int calc_cw(input int nch);
    return ($clog2(nch) < 1) ? 1 : $clog2(nch);
  endfunction

  // Header word layout {flag, channel, frame_count_lsbs}:
  // the flag sits at bit DW (same position as the group bit of data words).
  localparam logic HDR_FLAG = 1'b1;

  // Lowest bit of the channel field inside the DW-bit header payload.
  function automatic int hdr_ch_lsb(input int dw, input int cw);
    return dw - cw;
  endfunction

endpackage : lvds_pkg
`default_nettype wire

// File: rtl/lvds_ch_mux.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_ch_mux
//  Brief    : Registers all channel sample words and group flags every cycle
//             and selects one channel's {grp, data} from the registered copy.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module lvds_ch_mux #(
  parameter int DW  = 15,
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic                CLK_IN,
  input  logic                rst_n,
  input  logic [NCH*DW-1:0]   din,
  input  logic [NCH-1:0]      group_in,
  input  logic [CW-1:0]       ch,
  output logic [DW:0]         word
);

  logic [NCH*DW-1:0] din_r;
  logic [NCH-1:0]    grp_r;
  logic [DW-1:0]     lane [NCH];

  // Capture every channel each cycle so the selected word is one cycle old.
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      din_r <= '0;
      grp_r <= '0;
    end else begin
      din_r <= din;
      grp_r <= group_in;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    assign lane[c] = din_r[c*DW +: DW];
  end

  // Select the active channel's registered group flag and sample.
  always_comb begin
    word = {grp_r[ch], lane[ch]};
  end

endmodule : lvds_ch_mux
`default_nettype wire

// File: rtl/lvds_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_frame_writer
//  Brief    : Cuts one selected LVDS channel into fixed-length frames and
//             writes {group, data} words into the downstream FIFO, dropping
//             whole frame slots while the FIFO reports prog_full.
//             Build option LVDS_FRAME_HDR_EN prefixes each frame with a
//             header word {1, channel, frame_cnt lsbs}.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module lvds_frame_writer
  import lvds_pkg::*;
#(
  parameter  int DW        = 15,
  parameter  int NCH       = 4,
  parameter  int BURST_LEN = 512,
  parameter  int GAP_LEN   = 1,
  localparam int CW        = calc_cw(NCH)
) (
  input  logic                CLK_IN,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CW-1:0]       ch_sel,
  input  logic [NCH*DW-1:0]   din,
  input  logic [NCH-1:0]      group_in,
  input  logic                fifo_prog_full,
  output logic                fifo_wr_en,
  output logic [DW:0]         fifo_wr_data,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  // One counter serves DATA, SKIP and GAP, so it must cover the longest run.
  localparam int WCW       = $clog2(BURST_LEN + GAP_LEN + 1);
  localparam int GAP_LAST  = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

`ifdef LVDS_FRAME_HDR_EN
  localparam lvds_state_t FIRST_ST = ST_HDR;
  localparam int          HDR_LSB  = hdr_ch_lsb(DW, CW);
`else
  localparam lvds_state_t FIRST_ST = ST_DATA;
`endif

  lvds_state_t    state, state_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic [CW-1:0]  ch_r;
  logic           start_frame;
  logic           drop_slot;
  logic           wr_word;
  logic           last_word;
  logic [DW:0]    mux_word;
  logic [DW:0]    out_word;

  lvds_ch_mux #(
    .DW  (DW),
    .NCH (NCH),
    .CW  (CW)
  ) u_ch_mux (
    .CLK_IN   (CLK_IN),
    .rst_n    (rst_n),
    .din      (din),
    .group_in (group_in),
    .ch       (ch_r),
    .word     (mux_word)
  );

`ifdef LVDS_FRAME_HDR_EN
  logic        hdr_sel;
  logic [DW:0] hdr_word;

  // Header carries the pre-increment frame count of the frame it opens.
  assign hdr_word = {HDR_FLAG, ch_r, frame_cnt[HDR_LSB-1:0]};
  assign out_word = hdr_sel ? hdr_word : mux_word;
`else
  assign out_word = mux_word;
`endif

  // State and slot counter register.
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state decode: frame start / drop decision in IDLE, fixed-length runs after.
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    start_frame = 1'b0;
    drop_slot   = 1'b0;
    wr_word     = 1'b0;
    last_word   = 1'b0;
`ifdef LVDS_FRAME_HDR_EN
    hdr_sel     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (enable) begin
          wcnt_nxt = '0;
          if (!fifo_prog_full) begin
            start_frame = 1'b1;
            state_nxt   = FIRST_ST;
          end else begin
            drop_slot = 1'b1;
            state_nxt = ST_SKIP;
          end
        end
      end
`ifdef LVDS_FRAME_HDR_EN
      ST_HDR: begin
        wr_word   = 1'b1;
        hdr_sel   = 1'b1;
        state_nxt = ST_DATA;
      end
`endif
      ST_DATA: begin
        wr_word = 1'b1;
        if (wcnt == WCW'(BURST_LEN - 1)) begin
          last_word = 1'b1;
          wcnt_nxt  = '0;
          state_nxt = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
        end else begin
          wcnt_nxt = wcnt + WCW'(1);
        end
      end
      ST_SKIP: begin
        if (wcnt == WCW'(BURST_LEN - 1)) begin
          wcnt_nxt  = '0;
          state_nxt = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
        end else begin
          wcnt_nxt = wcnt + WCW'(1);
        end
      end
      ST_GAP: begin
        if (wcnt == WCW'(GAP_LAST)) begin
          wcnt_nxt  = '0;
          state_nxt = ST_IDLE;
        end else begin
          wcnt_nxt = wcnt + WCW'(1);
        end
      end
      default: begin
        wcnt_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Channel is frozen at frame start so mid-frame ch_sel changes are ignored.
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      ch_r <= '0;
    end else if (start_frame) begin
      ch_r <= ch_sel;
    end
  end

  // Registered FIFO write port; data holds its last value between frames.
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= wr_word;
      if (wr_word) begin
        fifo_wr_data <= out_word;
      end
    end
  end

  // Completed-frame counter (wraps) and dropped-slot counter (saturates).
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (last_word) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop_slot && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule : lvds_frame_writer
`default_nettype wire
